// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesting blocks and the round-robin arbiter.
// Latency: none (wires only); the arbiter registers every grant output.
// Backpressure: level-based request, held until the grant is no longer needed.
// Ports: req (4, requester side), gnt (4, one-hot), gnt_idx (2, decoder select), gnt_valid (1).
interface rr_decode_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  // master = requester side, slave = arbiter side
  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/rr_decode_arbiter.sv
// Four-requester round-robin arbiter steering a 2-to-4 decoder-selected shared resource.
// Latency: grant registered, visible one cycle after the request is sampled; handovers have no bubble.
// Backpressure: owner keeps the grant while its request is high, preempted after MAX_HOLD cycles if others wait.
// Ports: clk, rst_n (synchronous, active low), arb (slave modport: req in; gnt, gnt_idx, gnt_valid out).
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 8  // 0 = unlimited hold, legal 0..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_decode_arbiter_if.slave   arb
);

  localparam logic [7:0] HOLD_LIM = MAX_HOLD[7:0];

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [1:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic [3:0] gnt_q, gnt_d;

  logic [1:0] next_ptr;
  logic [3:0] others;
  logic       timeout;

  // Scan base, base+1, base+2, base+3 (2-bit wrap); the lowest offset with a
  // set mask bit wins, so the loop walks downward and keeps overwriting.
  function automatic logic [1:0] arb_pick(input logic [1:0] base, input logic [3:0] mask);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = base;
    for (int i = 3; i >= 0; i--) begin
      cand = base + 2'(i);
      if (mask[cand]) pick = cand;
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign next_ptr = idx_q + 2'd1;
  assign others   = arb.req & ~onehot(idx_q);
  assign timeout  = (HOLD_LIM != 8'd0) && (hcnt_q == HOLD_LIM);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (|arb.req) begin
          idx_d   = arb_pick(ptr_q, arb.req);
          vld_d   = 1'b1;
          hcnt_d  = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!arb.req[idx_q]) begin
          // Release: owner's bit is already clear, so req equals the others.
          ptr_d = next_ptr;
          if (|arb.req) begin
            idx_d  = arb_pick(next_ptr, arb.req);
            hcnt_d = 8'd1;
          end else begin
            idx_d   = 2'd0;
            vld_d   = 1'b0;
            hcnt_d  = 8'd0;
            state_d = IDLE;
          end
        end else if (timeout) begin
          // Preempt only if someone else is waiting; otherwise restart the hold window.
          ptr_d  = next_ptr;
          hcnt_d = 8'd1;
          if (|others) idx_d = arb_pick(next_ptr, others);
        end else if (hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = vld_d ? onehot(idx_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hcnt_q  <= 8'd0;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.gnt_idx   = idx_q;
  assign arb.gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: three instances (MAX_HOLD 4, 3, 0) share one request vector.
// Latency: expectations for cycle N+1 are queued when inputs for edge N are driven.
// Backpressure: requests held/dropped by directed sequences and random stimulus.
module tb_rr_decode_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } exp_t;

  typedef struct packed {
    int   cyc;
    exp_t e2;
    exp_t e1;
    exp_t e0;
  } exp3_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_r = 4'b0000;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp3_t exp_q[$];

  rr_decode_arbiter_if if0 ();
  rr_decode_arbiter_if if1 ();
  rr_decode_arbiter_if if2 ();

  assign if0.req = req_r;
  assign if1.req = req_r;
  assign if2.req = req_r;

  rr_decode_arbiter #(.MAX_HOLD(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .arb(if0));
  rr_decode_arbiter #(.MAX_HOLD(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .arb(if1));
  rr_decode_arbiter #(.MAX_HOLD(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .arb(if2));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int maxh [3] = '{4, 3, 0};
  int owner[3] = '{-1, -1, -1};
  int ptr  [3] = '{0, 0, 0};
  int hold [3] = '{0, 0, 0};

  // First requester at or after position p (circularly) whose mask bit is set.
  function automatic int rr_first(input int p, input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input logic rst_bit, input logic [3:0] r);
    logic [3:0] rest;
    if (!rst_bit) begin
      owner[k] = -1; ptr[k] = 0; hold[k] = 0;
    end else if (owner[k] < 0) begin
      if (r != 0) begin owner[k] = rr_first(ptr[k], r); hold[k] = 1; end
    end else if (!r[owner[k]]) begin
      ptr[k] = (owner[k] + 1) % 4;
      if (r != 0) begin owner[k] = rr_first(ptr[k], r); hold[k] = 1; end
      else begin owner[k] = -1; hold[k] = 0; end
    end else if (maxh[k] != 0 && hold[k] == maxh[k]) begin
      ptr[k] = (owner[k] + 1) % 4;
      rest = r;
      rest[owner[k]] = 1'b0;
      if (rest != 0) owner[k] = rr_first(ptr[k], rest);
      hold[k] = 1;
    end else begin
      hold[k] = (hold[k] < 255) ? hold[k] + 1 : 255;
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    if (owner[k] < 0) begin
      e.gnt = 4'b0000; e.idx = 2'd0; e.vld = 1'b0;
    end else begin
      e.gnt = 4'(1 << owner[k]); e.idx = 2'(owner[k]); e.vld = 1'b1;
    end
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst_bit, input logic [3:0] r);
    exp3_t x;
    @(negedge clk);
    rst_n = rst_bit;
    req_r = r;
    cyc++;
    for (int k = 0; k < 3; k++) model_step(k, rst_bit, r);
    x.cyc = cyc;
    x.e0  = model_out(0);
    x.e1  = model_out(1);
    x.e2  = model_out(2);
    exp_q.push_back(x);
  endtask

  task automatic drive_n(input int n, input logic rst_bit, input logic [3:0] r);
    for (int i = 0; i < n; i++) drive(rst_bit, r);
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input int k, input int c, input exp_t act, input exp_t exp);
    logic [3:0] dec;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL grant dut%0d cycle %0d: got gnt=%b idx=%0d vld=%b, expected gnt=%b idx=%0d vld=%b",
               k, c, act.gnt, act.idx, act.vld, exp.gnt, exp.idx, exp.vld);
    end
    dec = act.vld ? (4'b0001 << act.idx) : 4'b0000;
    checks++;
    if (act.gnt !== dec) begin
      errors++;
      $display("FAIL decode_invariant dut%0d cycle %0d: gnt=%b but decoder(idx=%0d, vld=%b)=%b",
               k, c, act.gnt, act.idx, act.vld, dec);
    end
  endtask

  initial begin
    exp3_t x;
    exp_t  a0, a1, a2;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x  = exp_q.pop_front();
        a0 = '{gnt: if0.gnt, idx: if0.gnt_idx, vld: if0.gnt_valid};
        a1 = '{gnt: if1.gnt, idx: if1.gnt_idx, vld: if1.gnt_valid};
        a2 = '{gnt: if2.gnt, idx: if2.gnt_idx, vld: if2.gnt_valid};
        cmp(0, x.cyc, a0, x.e0);
        cmp(1, x.cyc, a1, x.e1);
        cmp(2, x.cyc, a2, x.e2);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] r;
    logic       rb;
    int         budget;

    // Reset with every requester asserted, then first grant must be requester 0.
    drive_n(2, 1'b0, 4'b1111);
    drive_n(22, 1'b1, 4'b1111);   // timeout rotation on the MAX_HOLD=4/3 instances
    drive_n(2, 1'b1, 4'b0000);

    // Single request and release.
    drive_n(3, 1'b1, 4'b0100);
    drive_n(2, 1'b1, 4'b0000);

    // Release handover from owner 1 to owner 3.
    drive_n(1, 1'b0, 4'b0000);
    drive_n(1, 1'b1, 4'b0010);
    drive_n(2, 1'b1, 4'b1010);
    drive_n(3, 1'b1, 4'b1000);
    drive_n(1, 1'b1, 4'b0000);

    // Sole requester across several timeout windows.
    drive_n(10, 1'b1, 4'b0001);
    drive_n(1, 1'b1, 4'b0000);

    // Reset in the middle of a grant with the request still high.
    drive_n(2, 1'b1, 4'b0100);
    drive_n(1, 1'b0, 4'b0100);
    drive_n(3, 1'b1, 4'b0100);
    drive_n(2, 1'b1, 4'b1101);

    // Randomized traffic: requests change occasionally so grants both time out and release.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) r = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 199) != 0);
      drive(rb, r);
    end
    drive_n(2, 1'b1, 4'b0000);

    // Let the monitor drain the remaining expectations.
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Four-requester round-robin arbiter that shares one downstream resource selected by the 2-to-4 decoder.
- Produces a registered 2-bit grant index that drives the decoder select input, plus a matching one-hot grant vector.
- Ownership lasts until the owner drops its request, with optional preemption after a bounded hold time.
- Sits between the requesting blocks and the shared decoder-selected resource.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner while others wait; 0 = unlimited; legal range 0..255.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  4  request vector; bit i asserted = requester i wants the resource.
- gnt  output  4  registered one-hot grant; all zeros when no owner.
- gnt_idx  output  2  registered binary index of the owner; decoder select input; 0 when gnt_valid=0.
- gnt_valid  output  1  registered; 1 while an owner exists.

Behaviour:
- Reset: rst_n low at a clk edge sets:
  - state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0.
  - Internal priority pointer ptr=0; hold counter hcnt=0.
  - Reset has priority over every other event, including mid-grant; req is ignored that cycle.
- Invariant: gnt == (gnt_valid ? one-hot(gnt_idx) : 4'b0000) every cycle.
  - Bench must check gnt equals the output of the decoder driven by gnt_idx, gated by gnt_valid.
- Arbitration function ARB(mask):
  - Scan requesters in order ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - First index with req&mask set wins.
- IDLE, on a clk edge:
  - req==0: stay in IDLE.
  - Otherwise: winner=ARB(4'b1111); gnt_idx=winner, gnt_valid=1, hcnt=1, state->GRANT.
  - Latency: grant visible one cycle after the request is sampled.
- GRANT, on a clk edge, evaluated in priority order:
  1. Release, req[gnt_idx]==0:
     - ptr=gnt_idx+1 (mod 4).
     - Remaining req nonzero: hand over directly, with no bubble cycle, to ARB(all) using the new ptr; hcnt=1.
     - Remaining req zero: gnt_valid=0, gnt_idx=0, hcnt=0, state->IDLE.
  2. Timeout, MAX_HOLD!=0 and hcnt==MAX_HOLD:
     - ptr=gnt_idx+1 (mod 4).
     - Any other requester active: grant ARB(mask excluding current owner); hcnt=1.
     - No other requester active: current owner keeps the grant; hcnt=1.
  3. Otherwise: hold the grant; hcnt=hcnt+1 (saturates at 255 when MAX_HOLD=0).
- ptr changes only on release or timeout, never in IDLE.
- A requester that deasserts and reasserts before being granted has no memory; arbitration is purely level-based.
- Requests arriving in the same cycle as a release compete in that cycle's handover arbitration.
- No combinational path from req to any output.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0000, gnt_idx=0, gnt_valid=0 on both cycles; first grant after rst_n=1 is 0001.
2. Single request: after reset, req=0100 at edge N -> gnt=0100, gnt_idx=2, gnt_valid=1 at N+1; req=0000 at edge M -> gnt=0000, gnt_valid=0 at M+1.
3. Rotation by timeout: MAX_HOLD=4, req=1111 held -> gnt 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, 0001 x4; no bubble cycles.
4. Release handover: owner 1 holds gnt=0010 with req=1010; owner drops to req=1000 -> next cycle gnt=1000, gnt_idx=3, with no cycle of gnt_valid=0.
5. Sole requester timeout: MAX_HOLD=3, req=0001 held for 10 cycles -> gnt=0001 continuously; internal hcnt sequence 1,2,3,1,2,3...
6. Reset mid-grant: owner 2 at hcnt=2, rst_n=0 for one edge with req=0100 still high -> outputs zero that cycle; after release of reset, gnt=0100 is granted again with ptr=0 scan order.
